// File: rtl/memarb_pkg.sv
// rtl/memarb_pkg.sv - shared owner encoding and defaults for the fetch/data memory arbiter
package memarb_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam int STREAK_MAX_DEF = 3;

endpackage

// File: rtl/memarb.sv
// rtl/memarb.sv - single-port memory arbiter between instruction fetch and data access
// Data wins by default; fetch is forced through after STREAK_MAX consecutive data grants.
module memarb
    import memarb_pkg::*;
#(
    parameter int STREAK_MAX = STREAK_MAX_DEF,
    parameter int AW         = 16,
    parameter int DW         = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_adr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdat,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_adr,
    input  logic [DW-1:0] dm_wdat,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdat,
    input  logic          halt,
    input  logic          flush,
    output logic          stall_if,
    output logic          stall_mem,
    output logic [AW-1:0] mem_adr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdat,
    input  logic [DW-1:0] mem_rdat
);

    localparam int            SW   = $clog2(STREAK_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STREAK_MAX);

    logic [SW-1:0] streak;
    logic          inflight;
    owner_t        owner;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] wdat_q;
    logic          fetch_ok;
    logic          starve;

    assign fetch_ok = if_req && !halt;
    assign starve   = fetch_ok && (streak == SMAX);

    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (!reset) begin
            dm_gnt = dm_req && !starve;
            if_gnt = fetch_ok && !dm_gnt;
        end
    end

    assign stall_if  = fetch_ok && !if_gnt;
    assign stall_mem = dm_req && !dm_gnt;

    // Address and write data hold their last granted value when idle.
    assign mem_adr  = if_gnt ? if_adr : (dm_gnt ? dm_adr : adr_q);
    assign mem_wdat = dm_gnt ? dm_wdat : wdat_q;
    assign mem_we   = dm_gnt && dm_we;

    assign if_rdat  = mem_rdat;
    assign dm_rdat  = mem_rdat;

    // Reset in the response cycle discards it; flush only squashes fetch data.
    assign if_rvalid = inflight && (owner == OWN_IF) && !flush && !reset;
    assign dm_rvalid = inflight && (owner == OWN_DM) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            streak   <= '0;
            inflight <= 1'b0;
            owner    <= OWN_IF;
            adr_q    <= '0;
            wdat_q   <= '0;
        end else begin
            if (!if_req || halt || if_gnt) begin
                streak <= '0;
            end else if (dm_gnt && streak != SMAX) begin
                streak <= streak + SW'(1);
            end
            inflight <= if_gnt || (dm_gnt && !dm_we);
            if (if_gnt || dm_gnt) begin
                owner <= if_gnt ? OWN_IF : OWN_DM;
            end
            adr_q  <= mem_adr;
            wdat_q <= mem_wdat;
        end
    end

endmodule

// File: tb/tb_memarb.sv
// tb/tb_memarb.sv - randomized scoreboard bench for memarb against a behavioural model
module tb_memarb;

    localparam int SMAX = 3;

    logic        clk = 1'b0;
    logic        reset, if_req, dm_req, dm_we, halt, flush;
    logic [15:0] if_adr, dm_adr, dm_wdat;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, stall_if, stall_mem, mem_we;
    logic [15:0] if_rdat, dm_rdat, mem_adr, mem_wdat;
    logic [15:0] mem_rdat;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    logic [15:0] if_q[$];
    logic [15:0] dm_q[$];

    // Model state: outstanding read from last cycle and data grants since fetch last served
    bit          pend_v   = 1'b0;
    bit          pend_dm  = 1'b0;
    logic [15:0] pend_dat = '0;
    int          wait_cnt = 0;

    memarb #(.STREAK_MAX(SMAX), .AW(16), .DW(16)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_adr(if_adr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdat(if_rdat),
        .dm_req(dm_req), .dm_we(dm_we), .dm_adr(dm_adr), .dm_wdat(dm_wdat),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdat(dm_rdat),
        .halt(halt), .flush(flush), .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_adr(mem_adr), .mem_we(mem_we), .mem_wdat(mem_wdat), .mem_rdat(mem_rdat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_adr] <= mem_wdat;
        mem_rdat <= mem[mem_adr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, predict from the rules, check grants, advance the model.
    task automatic step(input bit ir, input logic [15:0] ia, input bit dr, input bit we,
                        input logic [15:0] da, input logic [15:0] wd, input bit h,
                        input bit fl, input bit rs, input int exp_dm);
        bit eig, edg, fetch_wants;
        reset = rs; if_req = ir; if_adr = ia; dm_req = dr; dm_we = we;
        dm_adr = da; dm_wdat = wd; halt = h; flush = fl;

        if (pend_v && !rs && !(!pend_dm && fl)) begin
            if (pend_dm) dm_q.push_back(pend_dat);
            else         if_q.push_back(pend_dat);
        end
        pend_v = 1'b0;

        fetch_wants = ir && !h;
        eig = 1'b0;
        edg = 1'b0;
        if (!rs) begin
            if (fetch_wants && wait_cnt >= SMAX) eig = 1'b1;
            else if (dr)                         edg = 1'b1;
            else if (fetch_wants)                eig = 1'b1;
        end

        #1;
        chk("if_gnt", if_gnt, eig);
        chk("dm_gnt", dm_gnt, edg);
        chk("stall_if", stall_if, fetch_wants && !eig);
        chk("stall_mem", stall_mem, dr && !edg);
        chk("mem_we", mem_we, edg && we);
        if (exp_dm >= 0) chk("dm_gnt_seq", dm_gnt, exp_dm[0]);

        if (eig) begin
            pend_v = 1'b1; pend_dm = 1'b0; pend_dat = ref_mem[ia];
        end else if (edg && !we) begin
            pend_v = 1'b1; pend_dm = 1'b1; pend_dat = ref_mem[da];
        end
        if (edg && we) ref_mem[da] = wd;

        if (rs || !fetch_wants || eig) wait_cnt = 0;
        else if (edg && wait_cnt < SMAX) wait_cnt++;

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, -1);
    endtask

    initial begin : monitor
        while (!done) begin
            @(negedge clk);
            #2;
            if (done) break;
            chk("if_rvalid", if_rvalid, if_q.size() > 0);
            if (if_rvalid && if_q.size() > 0) chk("if_rdat", if_rdat, if_q.pop_front());
            chk("dm_rvalid", dm_rvalid, dm_q.size() > 0);
            if (dm_rvalid && dm_q.size() > 0) chk("dm_rdat", dm_rdat, dm_q.pop_front());
            if_q.delete();
            dm_q.delete();
        end
    end

    initial begin : driver
        int seq [5] = '{1, 1, 1, 0, 1};
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[16'h0010] = 16'h1234;
        ref_mem[16'h0010] = 16'h1234;
        reset = 1'b1; if_req = 0; dm_req = 0; dm_we = 0; halt = 0; flush = 0;
        if_adr = '0; dm_adr = '0; dm_wdat = '0;
        @(negedge clk);

        step(0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 1, -1);
        step(1, 16'h4, 1, 0, 16'h8, 16'h0, 0, 0, 1, 0);
        step(1, 16'h0010, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0);
        idle();
        for (int i = 0; i < 5; i++) step(1, 16'h11, 1, 0, 16'h5, 16'h0, 0, 0, 0, seq[i]);
        idle();
        step(0, 16'h0, 1, 1, 16'h0020, 16'hBEEF, 0, 0, 0, 1);
        step(0, 16'h0, 1, 0, 16'h0020, 16'h0, 0, 0, 0, 1);
        idle();
        step(1, 16'h0010, 0, 0, 16'h0, 16'h0, 0, 0, 0, -1);
        step(0, 16'h0, 1, 0, 16'h0021, 16'h0, 0, 0, 0, -1);
        step(1, 16'h0012, 0, 0, 16'h0, 16'h0, 0, 0, 0, -1);
        step(0, 16'h0, 1, 0, 16'h0020, 16'h0, 0, 0, 0, -1);
        idle();
        step(1, 16'h0013, 0, 0, 16'h0, 16'h0, 1, 0, 0, -1);
        step(1, 16'h0013, 0, 0, 16'h0, 16'h0, 0, 0, 0, -1);
        step(0, 16'h0, 1, 0, 16'h0022, 16'h0, 0, 1, 0, -1);
        idle();
        step(0, 16'h0, 1, 0, 16'h0020, 16'h0, 0, 0, 0, -1);
        step(1, 16'h0010, 1, 0, 16'h0021, 16'h0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 16'h11, 1, 0, 16'h5, 16'h0, 0, 0, 0, seq[i]);
        idle();

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(3) != 0, 16'($urandom_range(31)),
                 $urandom_range(3) != 0, $urandom_range(2) == 0,
                 16'($urandom_range(31)), 16'($urandom),
                 $urandom_range(7) == 0, $urandom_range(5) == 0,
                 $urandom_range(49) == 0, -1);
        end
        idle();
        idle();
        done = 1'b1;
        #5;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
